// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/modify/write, ecall/mret/external-interrupt traps.
// Optional macro CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters.
module csr_trap_unit #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      HART_ID     = 0,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter logic [31:0]      MARCHID     = 32'h0180_0008
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic            ext_irq,
  output logic            trap_take,
  output logic [XLEN-1:0] trap_target,
  output logic            irq_pending
);

  // Interface: commit is the single qualifier for every state update; the decode inputs may be held
  // for any number of stall cycles. csr_rdata, illegal_csr, trap_take and trap_target are combinational.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] CAUSE_MEI   = (XLEN'(1) << (XLEN-1)) | XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  logic            r_mie_bit, r_mpie, r_meie, r_meip;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;

  logic [XLEN-1:0] w_mstatus, w_mie, w_mip, w_misa, w_old, w_new, w_tvec_base;
  logic [XLEN-1:0] w_mcycle_lo, w_mcycle_hi, w_minstret_lo, w_minstret_hi;
  logic            w_known, w_ro, w_wr_req, w_int_req;
  logic            w_int_take, w_ecall_take, w_mret_take, w_csr_we;

  always_comb begin
    w_mstatus = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7] = r_mpie;
    w_mstatus[3] = r_mie_bit;
    w_mie = '0;
    w_mie[11] = r_meie;
    w_mip = '0;
    w_mip[11] = r_meip;
    w_misa = '0;
    w_misa[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
    w_misa[8] = 1'b1;
  end

  always_comb begin
    w_old   = '0;
    w_known = 1'b1;
    w_ro    = 1'b0;
    case (csr_addr)
      A_MSTATUS:   w_old = w_mstatus;
      A_MISA:      begin w_old = w_misa; w_ro = 1'b1; end
      A_MIE:       w_old = w_mie;
      A_MTVEC:     w_old = r_mtvec;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MIP:       w_old = w_mip;
      A_MCYCLE:    w_old = w_mcycle_lo;
      A_MINSTRET:  w_old = w_minstret_lo;
      A_MCYCLEH:   begin w_old = w_mcycle_hi; w_known = (XLEN == 32); end
      A_MINSTRETH: begin w_old = w_minstret_hi; w_known = (XLEN == 32); end
      A_MVENDORID: w_ro = 1'b1;
      A_MARCHID:   begin w_old = XLEN'(MARCHID); w_ro = 1'b1; end
      A_MHARTID:   begin w_old = XLEN'(HART_ID); w_ro = 1'b1; end
      default:     w_known = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it never counts as a write to a read-only CSR.
  assign w_wr_req    = (csr_op == OP_RW) | (((csr_op == OP_RS) | (csr_op == OP_RC)) & (|csr_wdata));
  assign illegal_csr = (csr_op != OP_NONE) & (~w_known | (w_ro & w_wr_req));
  assign csr_rdata   = ((csr_op == OP_NONE) || illegal_csr) ? '0 : w_old;

  always_comb begin
    case (csr_op)
      OP_RW:   w_new = csr_wdata;
      OP_RS:   w_new = w_old | csr_wdata;
      OP_RC:   w_new = w_old & ~csr_wdata;
      default: w_new = w_old;
    endcase
  end

  assign w_int_req    = r_mie_bit & r_meie & r_meip;
  assign trap_take    = commit & (w_int_req | ecall | mret);
  assign w_int_take   = commit & w_int_req;
  assign w_ecall_take = commit & ~w_int_req & ecall;
  assign w_mret_take  = commit & ~w_int_req & ~ecall & mret;
  assign w_csr_we     = commit & ~trap_take & w_wr_req & ~illegal_csr;
  assign irq_pending  = r_meip;
  assign w_tvec_base  = {r_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    trap_target = w_tvec_base;
    if (w_int_req) begin
      if (r_mtvec[1:0] == 2'b01) trap_target = w_tvec_base + XLEN'(44);
    end else if (!ecall && mret) begin
      trap_target = r_mepc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mie_bit  <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_meip     <= 1'b0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      r_meip <= ext_irq;
      if (w_int_take || w_ecall_take) begin
        r_mepc    <= pc & ~XLEN'(3);
        r_mcause  <= w_int_take ? CAUSE_MEI : CAUSE_ECALL;
        r_mpie    <= r_mie_bit;
        r_mie_bit <= 1'b0;
      end else if (w_mret_take) begin
        r_mie_bit <= r_mpie;
        r_mpie    <= 1'b1;
      end else if (w_csr_we) begin
        case (csr_addr)
          A_MSTATUS:  begin r_mie_bit <= w_new[3]; r_mpie <= w_new[7]; end
          A_MIE:      r_meie <= w_new[11];
          A_MTVEC:    r_mtvec <= {w_new[XLEN-1:2], 1'b0, ~w_new[1] & w_new[0]};
          A_MSCRATCH: r_mscratch <= w_new;
          A_MEPC:     r_mepc <= w_new & ~XLEN'(3);
          A_MCAUSE:   r_mcause <= w_new;
          default:    ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle, r_minstret;
  logic        w_wr_cyc_lo, w_wr_cyc_hi, w_wr_ins_lo, w_wr_ins_hi;

  assign w_wr_cyc_lo   = w_csr_we & (csr_addr == A_MCYCLE);
  assign w_wr_cyc_hi   = w_csr_we & (csr_addr == A_MCYCLEH);
  assign w_wr_ins_lo   = w_csr_we & (csr_addr == A_MINSTRET);
  assign w_wr_ins_hi   = w_csr_we & (csr_addr == A_MINSTRETH);
  assign w_mcycle_lo   = r_mcycle[XLEN-1:0];
  assign w_mcycle_hi   = XLEN'(r_mcycle[63:32]);
  assign w_minstret_lo = r_minstret[XLEN-1:0];
  assign w_minstret_hi = XLEN'(r_minstret[63:32]);

  // A write to either half replaces that cycle's increment; the untouched half is kept as-is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_cyc_lo)
        r_mcycle <= (XLEN == 32) ? {r_mcycle[63:32], w_new[31:0]} : 64'(w_new);
      else if (w_wr_cyc_hi)
        r_mcycle <= {w_new[31:0], r_mcycle[31:0]};
      else
        r_mcycle <= r_mcycle + 64'd1;

      if (w_wr_ins_lo)
        r_minstret <= (XLEN == 32) ? {r_minstret[63:32], w_new[31:0]} : 64'(w_new);
      else if (w_wr_ins_hi)
        r_minstret <= {w_new[31:0], r_minstret[31:0]};
      else if (commit && !w_int_take)
        r_minstret <= r_minstret + 64'd1;
    end
  end
`else
  assign w_mcycle_lo   = '0;
  assign w_mcycle_hi   = '0;
  assign w_minstret_lo = '0;
  assign w_minstret_hi = '0;
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: vector table plus hand sequences for counters, simultaneous traps and async reset.
module tb_csr_trap_unit;

  localparam logic [1:0] OP_N = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  localparam int EW = 67;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        commit = 1'b0;
  logic [1:0]  csr_op = OP_N;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        ecall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc = '0;
  logic        ext_irq = 1'b0;
  logic        trap_take;
  logic [31:0] trap_target;
  logic        irq_pending;

  always #5 clock = ~clock;

  csr_trap_unit #(
    .XLEN(32), .HART_ID(3), .MTVEC_RESET(32'h0), .MARCHID(32'h0180_0008)
  ) dut (
    .clock(clock), .reset(reset), .commit(commit), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .ecall(ecall),
    .mret(mret), .pc(pc), .ext_irq(ext_irq), .trap_take(trap_take), .trap_target(trap_target),
    .irq_pending(irq_pending)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        cm, ec, mr, irq;
    logic [31:0] pc;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill, take;
    logic [31:0] tgt;
    logic        pend;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  logic          chk_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  vec_t          tbl[39];

  function automatic vec_t mkv(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                               input logic cm, input logic ec, input logic mr, input logic irq,
                               input logic [31:0] vpc, input logic chk_rd, input logic [31:0] rd,
                               input logic ill, input logic take, input logic [31:0] tgt,
                               input logic pend);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.cm = cm; v.ec = ec; v.mr = mr; v.irq = irq;
    v.pc = vpc; v.chk_rd = chk_rd; v.rd = rd; v.ill = ill; v.take = take; v.tgt = tgt;
    v.pend = pend;
    return v;
  endfunction

  function automatic vec_t csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                               input logic cm, input logic irq, input logic [31:0] rd,
                               input logic ill, input logic pend);
    return mkv(op, addr, wd, cm, 1'b0, 1'b0, irq, 32'h0, 1'b1, rd, ill, 1'b0, 32'h0, pend);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [EW-1:0] e;
    logic          c;
    @(posedge clock);
    #1;
    csr_op = v.op; csr_addr = v.addr; csr_wdata = v.wd; commit = v.cm;
    ecall = v.ec; mret = v.mr; ext_irq = v.irq; pc = v.pc;
    exp_q.push_back({v.rd, v.ill, v.take, v.tgt, v.pend});
    chk_q.push_back(v.chk_rd);
    @(negedge clock);
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    if (c) check("csr_rdata", idx, csr_rdata, e[66:35]);
    check("illegal_csr", idx, {31'b0, illegal_csr}, {31'b0, e[34]});
    check("trap_take", idx, {31'b0, trap_take}, {31'b0, e[33]});
    if (e[33]) check("trap_target", idx, trap_target, e[32:1]);
    check("irq_pending", idx, {31'b0, irq_pending}, {31'b0, e[0]});
  endtask

  initial begin
    tbl[0]  = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1800, 1'b0, 1'b0);
    tbl[1]  = csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[2]  = csr(OP_W, 12'h305, 32'h8000_0101, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[3]  = csr(OP_S, 12'h300, 32'h8, 1'b1, 1'b0, 32'h1800, 1'b0, 1'b0);
    tbl[4]  = csr(OP_S, 12'h304, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[5]  = csr(OP_S, 12'h305, 32'h0, 1'b0, 1'b0, 32'h8000_0101, 1'b0, 1'b0);
    tbl[6]  = csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    tbl[7]  = csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[8]  = mkv(OP_W, 12'h340, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 1'b1,
                  32'h0, 1'b0, 1'b1, 32'h8000_012C, 1'b1);
    tbl[9]  = csr(OP_S, 12'h341, 32'h0, 1'b0, 1'b0, 32'h8000_0040, 1'b0, 1'b1);
    tbl[10] = csr(OP_S, 12'h342, 32'h0, 1'b0, 1'b0, 32'h8000_000B, 1'b0, 1'b0);
    tbl[11] = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1880, 1'b0, 1'b0);
    tbl[12] = csr(OP_S, 12'h340, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[13] = csr(OP_W, 12'h305, 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0101, 1'b0, 1'b0);
    tbl[14] = csr(OP_S, 12'h300, 32'h8, 1'b1, 1'b0, 32'h1880, 1'b0, 1'b0);
    tbl[15] = mkv(OP_N, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 1'b1,
                  32'h0, 1'b0, 1'b1, 32'h8000_0100, 1'b0);
    tbl[16] = csr(OP_S, 12'h342, 32'h0, 1'b0, 1'b0, 32'hB, 1'b0, 1'b0);
    tbl[17] = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1880, 1'b0, 1'b0);
    tbl[18] = csr(OP_S, 12'h341, 32'h0, 1'b0, 1'b0, 32'h8000_0010, 1'b0, 1'b0);
    tbl[19] = mkv(OP_N, 12'h000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1,
                  32'h0, 1'b0, 1'b1, 32'h8000_0010, 1'b0);
    tbl[20] = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1888, 1'b0, 1'b0);
    tbl[21] = csr(OP_W, 12'hF11, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tbl[22] = csr(OP_S, 12'hF11, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[23] = csr(OP_S, 12'hF14, 32'h0, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0);
    tbl[24] = csr(OP_S, 12'hF12, 32'h0, 1'b0, 1'b0, 32'h0180_0008, 1'b0, 1'b0);
    tbl[25] = csr(OP_S, 12'h301, 32'h0, 1'b0, 1'b0, 32'h4000_0100, 1'b0, 1'b0);
    tbl[26] = csr(OP_W, 12'h7C0, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tbl[27] = csr(OP_W, 12'h341, 32'h1234_5677, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 1'b0);
    tbl[28] = csr(OP_S, 12'h341, 32'h0, 1'b0, 1'b0, 32'h1234_5674, 1'b0, 1'b0);
    tbl[29] = csr(OP_C, 12'h300, 32'h8, 1'b1, 1'b0, 32'h1888, 1'b0, 1'b0);
    tbl[30] = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1880, 1'b0, 1'b0);
    tbl[31] = csr(OP_W, 12'h305, 32'h3, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 1'b0);
    tbl[32] = csr(OP_S, 12'h305, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[33] = csr(OP_S, 12'hF12, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tbl[34] = csr(OP_C, 12'hF14, 32'h0, 1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    tbl[35] = csr(OP_W, 12'h304, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h800, 1'b0, 1'b0);
    tbl[36] = csr(OP_S, 12'h304, 32'h0, 1'b0, 1'b0, 32'h800, 1'b0, 1'b0);
    tbl[37] = csr(OP_W, 12'h300, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1880, 1'b0, 1'b0);
    tbl[38] = csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1888, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 39; i++) run_vec(tbl[i], i);

    // Counters: clear minstret, retire ten instructions, then roll mcycle's low word over.
    run_vec(mkv(OP_W, 12'hB02, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, !CNT, 32'h0, 1'b0, 1'b0,
                32'h0, 1'b0), 100);
    for (int i = 0; i < 10; i++) run_vec(csr(OP_N, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), 101 + i);
    run_vec(csr(OP_S, 12'hB02, 32'h0, 1'b0, 1'b0, CNT ? 32'd10 : 32'd0, 1'b0, 1'b0), 111);
    run_vec(csr(OP_S, 12'hB82, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 112);
    run_vec(mkv(OP_W, 12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, !CNT, 32'h0, 1'b0,
                1'b0, 32'h0, 1'b0), 113);
    run_vec(csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 114);
    run_vec(csr(OP_S, 12'hB80, 32'h0, 1'b0, 1'b0, CNT ? 32'd1 : 32'd0, 1'b0, 1'b0), 115);
    run_vec(csr(OP_S, 12'hB00, 32'h0, 1'b0, 1'b0, CNT ? 32'd1 : 32'd0, 1'b0, 1'b0), 116);

    // ecall and a pending interrupt on the same commit resolve as the interrupt.
    run_vec(csr(OP_W, 12'h305, 32'h8000_0101, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), 200);
    run_vec(csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0), 201);
    run_vec(mkv(OP_N, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0020, 1'b1, 32'h0, 1'b0,
                1'b1, 32'h8000_012C, 1'b1), 202);
    run_vec(csr(OP_S, 12'h342, 32'h0, 1'b0, 1'b0, 32'h8000_000B, 1'b0, 1'b1), 203);
    run_vec(csr(OP_S, 12'h341, 32'h0, 1'b0, 1'b0, 32'h8000_0020, 1'b0, 1'b0), 204);

    // Same collision again, but reset lands mid-cycle before the commit edge.
    run_vec(csr(OP_W, 12'h340, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0), 300);
    run_vec(csr(OP_S, 12'h300, 32'h8, 1'b1, 1'b0, 32'h1880, 1'b0, 1'b0), 301);
    run_vec(csr(OP_N, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0), 302);
    @(posedge clock);
    #1;
    csr_op = OP_N; commit = 1'b1; ecall = 1'b1; ext_irq = 1'b1; pc = 32'h8000_0030;
    #1;
    check("trap_take", 303, {31'b0, trap_take}, 32'h1);
    check("trap_target", 303, trap_target, 32'h8000_012C);
    #1 reset = 1'b1;
    #1;
    check("irq_pending", 303, {31'b0, irq_pending}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0; commit = 1'b0; ecall = 1'b0; ext_irq = 1'b0; pc = '0;
    run_vec(csr(OP_S, 12'h300, 32'h0, 1'b0, 1'b0, 32'h1800, 1'b0, 1'b0), 304);
    run_vec(csr(OP_S, 12'h340, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 305);
    run_vec(csr(OP_S, 12'h341, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 306);
    run_vec(csr(OP_S, 12'h342, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 307);
    run_vec(csr(OP_S, 12'h305, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 308);
    run_vec(csr(OP_S, 12'h304, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 309);
    run_vec(csr(OP_S, 12'hB82, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 310);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the ysyx24080008 core family.
- Replaces the hard-coded four-register CSR logic with an extended CSR set, a vectored mtvec mode, external-interrupt acceptance from io_interrupt, and cycle/instret counters.
- Sits beside the register file. All architectural updates are gated by the core's per-instruction commit strobe, so multi-cycle AXI fetch/load stalls are tolerated.

Parameters:
- XLEN, 32, data width; legal values are 32 and 64.
- HART_ID, 0, value read from mhartid.
- MTVEC_RESET, 0, reset value of mtvec.
- MARCHID, 32'h0180_0008, value read from marchid.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- commit  in  1  the current instruction retires this cycle; all state writes happen only on this edge
- csr_op  in  2  00 none, 01 csrrw, 10 csrrs, 11 csrrc
- csr_addr  in  12  CSR address (ist[31:20])
- csr_wdata  in  XLEN  rs1 value
- csr_rdata  out  XLEN  old CSR value, combinational; goes to rd
- illegal_csr  out  1  access to an unknown CSR, or a write to a read-only CSR
- ecall  in  1  decoded ecall
- mret  in  1  decoded mret
- pc  in  XLEN  PC of the current instruction
- ext_irq  in  1  io_interrupt, level-sensitive
- trap_take  out  1  redirect to trap_target this commit
- trap_target  out  XLEN  trap entry PC, or mepc for mret
- irq_pending  out  1  registered MEIP

Behaviour:
- Registers: mstatus (MIE bit 3, MPIE bit 7, MPP[12:11] hardwired 2'b11), mie (MEIE bit 11 only), mtvec, mscratch, mepc (bits[1:0] forced 0), mcause, mip (MEIP bit 11, read-only), mcycle, minstret.
- Read-only CSRs: misa (RV32I/RV64I), mvendorid = 0, marchid, mhartid.
- Reset values: mstatus = 0x1800, mie = 0, mtvec = MTVEC_RESET, all others 0, mip.MEIP = 0.
- Resulting output reset values: csr_rdata = 0 while csr_op = none, trap_take = 0, irq_pending = 0.
- MEIP is ext_irq registered once (1-cycle latency); it is not latched and clears when ext_irq drops.
- Interrupt condition: int_req = mstatus.MIE & mie.MEIE & MEIP.
- Trap priority at commit: int_req > ecall > mret.
- Interrupt taken:
  - mepc = pc of the committing instruction.
  - That instruction's own CSR write, and its rd write in the core, are suppressed. The core must treat trap_take as a squash.
  - mcause = {1, 0..., 11}.
- ecall: mepc = pc, mcause = 11.
- On any trap: MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1, trap_target = mepc.
- trap_target:
  - Direct mode (mtvec[1:0] = 00): {mtvec[XLEN-1:2], 2'b00}.
  - Vectored mode (01): base + 4*cause for interrupts; base for exceptions.
  - Mode values 1x are written as 00.
- trap_take is combinational: commit & (int_req | ecall | mret).
- CSR ops:
  - csrrw writes csr_wdata.
  - csrrs ORs csr_wdata into the CSR; csrrc clears the bits set in csr_wdata.
  - csrrs or csrrc with csr_wdata = 0 performs no write and never flags illegal on read-only CSRs.
- Illegal access: no state change and csr_rdata = 0.
- Counters:
  - mcycle increments every clock; minstret increments on commit & ~trap_take-by-interrupt.
  - Both are 64-bit. With XLEN = 32, the low word is at 0xB00/0xB02 and the high word at 0xB80/0xB82. With XLEN = 64, the high addresses are illegal.
  - A CSR write to a counter word overrides that cycle's increment for the whole counter; the other half is kept.
  - Wrap from all-ones to 0 without a flag.
- Simultaneous events: an ecall and a pending interrupt on the same commit are handled as the interrupt, with mcause = interrupt.
- reset mid-operation clears all state asynchronously; a pending commit is lost.

Optional Feature:
- CSR_COUNTERS_EN:
  - Defined: mcycle, minstret and their high halves are implemented as above.
  - Undefined: the counter addresses read 0, writes are ignored, illegal_csr stays 0 for them, and no counter flops are synthesised.

Test Plan:
- Reset, then csr_op = csrrs, addr 0x300, wdata 0 -> csr_rdata = 0x1800 and illegal_csr = 0.
- csrrw 0x305 = 0x8000_0101, set mstatus.MIE and mie.MEIE, raise ext_irq, commit at pc 0x8000_0040:
  - irq_pending = 1 one cycle after ext_irq rises.
  - trap_take = 1 and trap_target = 0x8000_012C.
  - mepc = 0x8000_0040, mcause = 0x8000_000B, MIE = 0, MPIE = 1.
- ecall with mtvec = 0x8000_0100 at pc 0x8000_0010 -> trap_target = 0x8000_0100, mcause = 11; a following mret -> trap_target = 0x8000_0010 and MIE restored.
- csrrw 0xF11 with wdata 5 -> illegal_csr = 1, no write; csrrs 0xF14 with wdata 0 -> csr_rdata = HART_ID.
- With CSR_COUNTERS_EN, write mcycle = 0xFFFF_FFFF, wait 2 cycles -> mcycleh = 1; 10 commits with no trap -> minstret = 10.
- ecall and a pending interrupt on the same commit -> mcause = 0x8000_000B; asserting reset during that cycle -> all CSRs return to their reset values.
